// File: rtl/wb_arbiter_2m_if.sv
// Single Wishbone link: master-to-slave request signals plus the slave's response.
// The arbiter uses the slave modport toward each CPU connector and the master modport toward the interconnect.
interface wb_arbiter_2m_if;
  logic        cyc;
  logic        stb;
  logic [29:0] addr;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, addr, cti, bte, sel, we, dat_w,
                  input  dat_r, ack, err);
  modport slave  (input  cyc, stb, addr, cti, bte, sel, we, dat_w,
                  output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter (m0 = data side, m1 = instruction side) driving one shared bus.
// Grants are held for a whole cyc; a watchdog turns a hung slave into a one-cycle err.
module wb_arbiter_2m #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT     = 255,
  parameter int TMR_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_arbiter_2m_if.slave        m0,
  wb_arbiter_2m_if.slave        m1,
  wb_arbiter_2m_if.master       s,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1, S_ABORT} state_t;

  // Abort fires when this count is already reached and one more stb cycle goes unanswered.
  localparam logic [TMR_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic             prio, prio_nx;
  logic             owner, owner_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic             timeout_nx;
  logic             own_cyc;
  logic             s_resp;
  logic             tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      timer     <= '0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nx;
      prio      <= prio_nx;
      owner     <= owner_nx;
      timer     <= timer_nx;
      timeout_o <= timeout_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    prio_nx    = prio;
    owner_nx   = owner;
    timer_nx   = '0;
    timeout_nx = 1'b0;
    tmo_hit    = 1'b0;
    own_cyc    = owner ? m1.cyc : m0.cyc;
    s_resp     = s.ack | s.err;
    case (state)
      S_IDLE: begin
        if (m0.cyc && (!m1.cyc || !prio)) begin
          state_nx = S_GNT0;
          owner_nx = 1'b0;
        end else if (m1.cyc) begin
          state_nx = S_GNT1;
          owner_nx = 1'b1;
        end
      end
      S_GNT0, S_GNT1: begin
        if (s.stb && !s_resp) begin
          timer_nx = (timer == '1) ? timer : timer + TMR_W'(1);
        end
        tmo_hit = (TIMEOUT != 0) && s.stb && !s_resp && (timer == TMO_LAST);
        if (!own_cyc) begin
          state_nx = S_IDLE;
          if (ROUND_ROBIN) prio_nx = ~owner;
        end else if (tmo_hit) begin
          state_nx   = S_ABORT;
          timeout_nx = 1'b1;
        end
      end
      S_ABORT: begin
        if (!own_cyc) begin
          state_nx = S_IDLE;
          if (ROUND_ROBIN) prio_nx = ~owner;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The owner's request drives the shared bus; responses reach only the owner.
  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.addr  = '0;
    s.cti   = '0;
    s.bte   = '0;
    s.sel   = '0;
    s.we    = 1'b0;
    s.dat_w = '0;
    m0.ack  = 1'b0;
    m0.err  = 1'b0;
    m1.ack  = 1'b0;
    m1.err  = 1'b0;
    case (state)
      S_GNT0: begin
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        s.addr  = m0.addr;
        s.cti   = m0.cti;
        s.bte   = m0.bte;
        s.sel   = m0.sel;
        s.we    = m0.we;
        s.dat_w = m0.dat_w;
        m0.ack  = s.ack;
        m0.err  = s.err;
      end
      S_GNT1: begin
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        s.addr  = m1.addr;
        s.cti   = m1.cti;
        s.bte   = m1.bte;
        s.sel   = m1.sel;
        s.we    = m1.we;
        s.dat_w = m1.dat_w;
        m1.ack  = s.ack;
        m1.err  = s.err;
      end
      S_ABORT: begin
        m0.err = timeout_o & ~owner;
        m1.err = timeout_o & owner;
      end
      default: ;
    endcase
  end

  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign grant_o  = {state == S_GNT1, state == S_GNT0};

endmodule
